// File: rtl/register_writeback_file_if.sv
// register_writeback_file_if: write-request, read-address and read-data bundle for the writeback register file.
//   master : drives invertedNotALUResult, PR_WriteIn, PR_WriteAddr, PR_ReadAddrA/B;
//            receives notReadDataA/B, WritePending, CommitCount
//   slave  : the register file side of the same signals
interface register_writeback_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] invertedNotALUResult;
    logic              PR_WriteIn;
    logic [ADDR_W-1:0] PR_WriteAddr;
    logic [ADDR_W-1:0] PR_ReadAddrA;
    logic [ADDR_W-1:0] PR_ReadAddrB;
    logic [DATA_W-1:0] notReadDataA;
    logic [DATA_W-1:0] notReadDataB;
    logic              WritePending;
    logic [7:0]        CommitCount;

    modport master (
        output invertedNotALUResult, PR_WriteIn, PR_WriteAddr, PR_ReadAddrA, PR_ReadAddrB,
        input  notReadDataA, notReadDataB, WritePending, CommitCount
    );

    modport slave (
        input  invertedNotALUResult, PR_WriteIn, PR_WriteAddr, PR_ReadAddrA, PR_ReadAddrB,
        output notReadDataA, notReadDataB, WritePending, CommitCount
    );
endinterface

// File: rtl/register_writeback_file.sv
// register_writeback_file: two-stage (latch, commit) active-low register file with two forwarding read ports.
//   CLK   in   rising-edge clock
//   RST   in   synchronous active-high reset; clears array to 'hFFFF, drops any latched write
//   bus   slave modport of register_writeback_file_if:
//         invertedNotALUResult/PR_WriteIn/PR_WriteAddr  write request, latched then committed
//         PR_ReadAddrA/B -> notReadDataA/B              combinational reads, forwarded from the latch
//         WritePending                                  latch holds an uncommitted write
//         CommitCount                                   committed writes, modulo 256
// Optional: define REGISTER_WRITEBACK_R0_ZERO_EN to hardwire register 0 to active-low zero.
module register_writeback_file #(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    register_writeback_file_if.slave      bus
);
`ifdef REGISTER_WRITEBACK_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic              w_valid_q, w_valid_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];
    logic              w_to_r0;
    logic              array_we;

    // A latched write to the hardwired register still counts but never reaches the array or the read ports.
    assign w_to_r0  = R0_ZERO && (w_addr_q == '0);
    assign array_we = w_valid_q && !w_to_r0;

    always_comb begin
        w_valid_d = bus.PR_WriteIn;
        w_addr_d  = bus.PR_WriteIn ? bus.PR_WriteAddr : w_addr_q;
        w_data_d  = bus.PR_WriteIn ? bus.invertedNotALUResult : w_data_q;
        cnt_d     = w_valid_q ? cnt_q + 8'd1 : cnt_q;
        regs_d    = regs_q;
        if (array_we) regs_d[w_addr_q] = w_data_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_valid_q <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '1;
            cnt_q     <= '0;
            regs_q    <= '{default: '1};
        end else begin
            w_valid_q <= w_valid_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            cnt_q     <= cnt_d;
            regs_q    <= regs_d;
        end
    end

    // Forwarding from the latch makes a read one cycle after the write see the new value.
    assign bus.notReadDataA = (R0_ZERO && bus.PR_ReadAddrA == '0) ? '1 :
                              (array_we && w_addr_q == bus.PR_ReadAddrA) ? w_data_q : regs_q[bus.PR_ReadAddrA];
    assign bus.notReadDataB = (R0_ZERO && bus.PR_ReadAddrB == '0) ? '1 :
                              (array_we && w_addr_q == bus.PR_ReadAddrB) ? w_data_q : regs_q[bus.PR_ReadAddrB];
    assign bus.WritePending = w_valid_q;
    assign bus.CommitCount  = cnt_q;
endmodule

// File: tb/tb_register_writeback_file.sv
// tb_register_writeback_file: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_register_writeback_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_writeback_file_if #(.DATA_W(16), .ADDR_W(3)) bus_if ();

    register_writeback_file dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus_if)
    );

    typedef struct {
        string       name;
        bit          ca, cb, cp, cc;
        logic [15:0] a, b;
        logic        p;
        logic [7:0]  c;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic exp_t mk(string name, bit ca, logic [15:0] a, bit cb, logic [15:0] b,
                                bit cp, logic p, bit cc, logic [7:0] c);
        exp_t e;
        e.name = name; e.ca = ca; e.a = a; e.cb = cb; e.b = b;
        e.cp = cp; e.p = p; e.cc = cc; e.c = c;
        return e;
    endfunction

    task automatic chk(string name, string fld, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", name, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.ca) chk(e.name, "A", bus_if.notReadDataA, e.a);
            if (e.cb) chk(e.name, "B", bus_if.notReadDataB, e.b);
            if (e.cp) chk(e.name, "pend", {15'd0, bus_if.WritePending}, {15'd0, e.p});
            if (e.cc) chk(e.name, "cnt", {8'd0, bus_if.CommitCount}, {8'd0, e.c});
        end
    end

    // One call = one cycle: drive after the edge, queue what the monitor must see in this cycle.
    task automatic cyc(logic r, logic we, logic [2:0] wa, logic [15:0] wd,
                       logic [2:0] ra, logic [2:0] rb, exp_t e);
        @(posedge clk);
        #1;
        rst = r;
        bus_if.PR_WriteIn = we;
        bus_if.PR_WriteAddr = wa;
        bus_if.invertedNotALUResult = wd;
        bus_if.PR_ReadAddrA = ra;
        bus_if.PR_ReadAddrB = rb;
        q.push_back(e);
    endtask

    function automatic logic [15:0] sweep_data(int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b};
    endfunction

    exp_t none;
    logic [15:0] exp0;

    initial begin
        none = mk("none", 0, 0, 0, 0, 0, 0, 0, 0);
        bus_if.PR_WriteIn = 1'b0;
        bus_if.PR_WriteAddr = '0;
        bus_if.invertedNotALUResult = '1;
        bus_if.PR_ReadAddrA = '0;
        bus_if.PR_ReadAddrB = '0;
        cyc(1, 0, 0, 0, 0, 0, none);
        cyc(1, 1, 6, 16'h0000, 0, 0, none);
        // reset state, every address on both ports
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 0, 3'(i), 3'(7 - i), mk("reset", 1, 16'hFFFF, 1, 16'hFFFF, 1, 0, 1, 0));
        // basic write with forwarding
        cyc(0, 1, 3, 16'h12ED, 3, 3, mk("bw0", 1, 16'hFFFF, 0, 0, 1, 0, 1, 0));
        cyc(0, 0, 0, 16'h0000, 3, 3, mk("bw1", 1, 16'h12ED, 1, 16'h12ED, 1, 1, 1, 0));
        cyc(0, 0, 0, 16'h0000, 3, 0, mk("bw2", 1, 16'h12ED, 0, 0, 1, 0, 1, 1));
        cyc(0, 0, 0, 16'h0000, 3, 0, mk("bw3", 1, 16'h12ED, 0, 0, 1, 0, 1, 1));
        // back-to-back to one address
        cyc(0, 1, 5, 16'hAAAA, 0, 5, mk("bb0", 0, 0, 1, 16'hFFFF, 0, 0, 1, 1));
        cyc(0, 1, 5, 16'h5555, 0, 5, mk("bb1", 0, 0, 1, 16'hAAAA, 1, 1, 1, 1));
        cyc(0, 0, 0, 16'h0000, 0, 5, mk("bb2", 0, 0, 1, 16'h5555, 1, 1, 1, 2));
        cyc(0, 0, 0, 16'h0000, 0, 5, mk("bb3", 0, 0, 1, 16'h5555, 1, 0, 1, 3));
        // full sweep
        for (int i = 0; i < 8; i++) cyc(0, 1, 3'(i), sweep_data(i), 0, 0, none);
        cyc(0, 0, 0, 0, 0, 0, none);
        cyc(0, 0, 0, 0, 0, 0, mk("sw_cnt", 0, 0, 0, 0, 1, 0, 1, 11));
`ifdef REGISTER_WRITEBACK_R0_ZERO_EN
        exp0 = 16'hFFFF;
`else
        exp0 = 16'h00FF;
`endif
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 0, 3'(i), 3'(i), mk("sweep", 1, i == 0 ? exp0 : sweep_data(i),
                                              1, i == 0 ? exp0 : sweep_data(i), 0, 0, 1, 11));
        cyc(0, 0, 0, 0, 2, 6, mk("cross", 1, 16'h02FD, 1, 16'h06F9, 0, 0, 0, 0));
        // reset mid-operation: latched write is discarded, reset beats a same-cycle write
        cyc(0, 1, 2, 16'h0F0F, 2, 2, mk("rm0", 1, 16'h02FD, 0, 0, 1, 0, 1, 11));
        cyc(1, 1, 2, 16'h0000, 2, 2, mk("rm1", 1, 16'h0F0F, 0, 0, 1, 1, 1, 11));
        cyc(0, 0, 0, 16'h0000, 2, 3, mk("rm2", 1, 16'hFFFF, 1, 16'hFFFF, 1, 0, 1, 0));
        cyc(0, 0, 0, 16'h0000, 2, 5, mk("rm3", 1, 16'hFFFF, 1, 16'hFFFF, 1, 0, 1, 0));
        // counter wrap
        for (int k = 0; k < 255; k++) cyc(0, 1, 1, 16'hC000 | 16'(k), 0, 0, none);
        cyc(0, 0, 0, 0, 1, 1, mk("wr254", 0, 0, 0, 0, 1, 1, 1, 254));
        cyc(0, 1, 1, 16'hBEEF, 1, 1, mk("wr255", 1, 16'hC0FE, 0, 0, 1, 0, 1, 255));
        cyc(0, 0, 0, 0, 1, 1, mk("wr_fwd", 1, 16'hBEEF, 1, 16'hBEEF, 1, 1, 1, 255));
        cyc(0, 0, 0, 0, 1, 0, mk("wr0", 1, 16'hBEEF, 0, 0, 1, 0, 1, 0));
        for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register_writeback_file.md
Name: register_writeback_file

Overview:
- Downstream consumer of the byte-swap/invert stage: captures the 16-bit active-low result (invertedNotALUResult) and commits it into a small register file.
- Write path is two stages:
  - W stage: write-request latch.
  - C stage: array commit.
- Two combinational read ports with W-stage forwarding, so a read-after-write in the next cycle returns the new value.
- Data is stored active-low throughout; "zero" is 16'hFFFF.

Parameters:
- DATA_W, 16, data width; must be even, because the upstream swap works on byte halves.
- REG_COUNT, 8, number of registers.
- ADDR_W, 3, address width; REG_COUNT must equal 2**ADDR_W.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- invertedNotALUResult  in  DATA_W  active-low write data from the invert stage.
- PR_WriteIn  in  1  write request, sampled each cycle.
- PR_WriteAddr  in  ADDR_W  destination register.
- PR_ReadAddrA  in  ADDR_W  read port A address.
- PR_ReadAddrB  in  ADDR_W  read port B address.
- notReadDataA  out  DATA_W  active-low read data, port A.
- notReadDataB  out  DATA_W  active-low read data, port B.
- WritePending  out  1  W-stage latch holds an uncommitted write.
- CommitCount  out  8  number of committed writes, wraps modulo 256.

Behaviour:
- Reset, while RST=1 at the clock edge:
  - All REG_COUNT registers are set to 16'hFFFF.
  - W latch is cleared: valid=0, addr=0, data=16'hFFFF.
  - CommitCount=0.
  - RST takes priority over any PR_WriteIn in the same cycle.
  - A write sitting in the W latch when reset arrives is discarded and never commits.
- W stage:
  - On each edge, the W latch loads valid=PR_WriteIn, addr=PR_WriteAddr and data=invertedNotALUResult.
  - Data and address are loaded only when PR_WriteIn=1; otherwise they hold and only valid clears.
- C stage:
  - On each edge where the W latch has valid=1, reg[W.addr] is set to W.data and CommitCount increments by 1.
  - CommitCount wraps from 255 to 0.
- Latency:
  - A write presented in cycle N is in the W latch during cycle N+1 and in the array from cycle N+2.
  - Back-to-back writes on every cycle are sustained, one commit per cycle.
  - No stall and no backpressure.
- Reads are combinational. For port X:
  - If W.valid=1 and W.addr==ReadAddrX, notReadDataX = W.data (forwarding).
  - Otherwise notReadDataX = reg[ReadAddrX].
  - A write presented this cycle (not yet latched) is not visible this cycle.
- Simultaneous events:
  - Consecutive writes to the same address: the later one wins; forwarding always shows the newest latched value.
  - A write to address a in cycle N and a read of a in cycle N+1 returns the new data.
  - Both ports reading the same address return identical data.
- WritePending equals W.valid. It is 0 out of reset and 1 for exactly one cycle per accepted write.
- The block does no arithmetic on data; it stores bits verbatim and never re-inverts or swaps.

Optional Feature:
- Macro: REGISTER_WRITEBACK_R0_ZERO_EN.
- When defined, register 0 is hardwired to zero (16'hFFFF active-low):
  - Writes to address 0 are ignored by the array and are not forwarded.
  - Reads of address 0 always return 16'hFFFF.
  - Writes to address 0 still pass through the W latch and still increment CommitCount.
- When undefined, register 0 is an ordinary register.

Test Plan:
- Reset check: hold RST=1 for 2 cycles, release.
  -> Both read ports return 16'hFFFF for every address.
  -> WritePending=0 and CommitCount=0.
- Basic write: write addr=3, data=16'h12ED in cycle 0; read port A addr=3.
  -> Cycle 0 returns 16'hFFFF.
  -> Cycle 1 returns 16'h12ED via forwarding, with WritePending=1.
  -> Cycle 2 onward returns 16'h12ED from the array, with WritePending=0 and CommitCount=1.
- Back-to-back to one address: write addr=5 with 16'hAAAA, then 16'h5555, on consecutive cycles; read port B addr=5.
  -> Returns 16'hAAAA, then 16'h5555, then stays 16'h5555.
  -> CommitCount=2.
- Full sweep: write addr i with data {i,~i} for i=0..7 over 8 consecutive cycles, wait 2 cycles.
  -> Both ports read every address correctly.
  -> CommitCount=8.
  -> With REGISTER_WRITEBACK_R0_ZERO_EN, address 0 instead reads 16'hFFFF while CommitCount is still 8.
- Reset mid-operation: write addr=2 with 16'h0F0F in cycle 0, assert RST in cycle 1.
  -> Address 2 reads 16'hFFFF after reset.
  -> CommitCount=0.
- Counter wrap: perform 256 writes.
  -> CommitCount reads 0 afterwards.
  -> It reads 255 after the 255th commit.
